// File: rtl/cpu_pkg.sv
// Shared CPU definitions: forwarding selects, hazard-controller states and
// the hard-wired zero register number.
package cpu_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        ERR     = 2'b10
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master = controller side, slave = datapath side.
interface pipe_hazard_ctrl_if;
    import cpu_pkg::*;

    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_branch_taken;
    logic        ex_wreg;
    logic        ex_m2reg;
    logic [4:0]  ex_wn;
    logic        mem_wreg;
    logic        mem_m2reg;
    logic        mem_wmem;
    logic [4:0]  mem_wn;
    logic        dmem_ack;

    logic        pc_we;
    logic        ifid_we;
    logic        idex_we;
    logic        exmem_we;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        memwb_bubble;
    fwd_sel_t    fwda;
    fwd_sel_t    fwdb;
    logic        bus_err;
    logic [31:0] stall_cycles;

    modport master (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch_taken,
               ex_wreg, ex_m2reg, ex_wn,
               mem_wreg, mem_m2reg, mem_wmem, mem_wn, dmem_ack,
        output pc_we, ifid_we, idex_we, exmem_we,
               ifid_flush, idex_bubble, memwb_bubble,
               fwda, fwdb, bus_err, stall_cycles
    );

    modport slave (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_branch_taken,
               ex_wreg, ex_m2reg, ex_wn,
               mem_wreg, mem_m2reg, mem_wmem, mem_wn, dmem_ack,
        input  pc_we, ifid_we, idex_we, exmem_we,
               ifid_flush, idex_bubble, memwb_bubble,
               fwda, fwdb, bus_err, stall_cycles
    );

endinterface

// File: rtl/fwd_unit.sv
// Operand forwarding select for one ID source register; EX beats MEM, and a
// load in EX cannot forward because its data is not ready yet.
module fwd_unit
    import cpu_pkg::*;
(
    input  logic [4:0] src,
    input  logic       ex_wreg,
    input  logic       ex_m2reg,
    input  logic [4:0] ex_wn,
    input  logic       mem_wreg,
    input  logic [4:0] mem_wn,
    output fwd_sel_t   fwd
);

    always_comb begin
        if (ex_wreg && !ex_m2reg && ex_wn != REG_ZERO && ex_wn == src)
            fwd = FWD_EX;
        else if (mem_wreg && mem_wn != REG_ZERO && mem_wn == src)
            fwd = FWD_MEM;
        else
            fwd = FWD_RF;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use bubbles, branch flushes,
// data-memory wait freeze with timeout to a sticky bus error.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               clrn,
    pipe_hazard_ctrl_if.master bus
);

    localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wcnt;
    logic        bus_err_q;
    logic [31:0] stall_q;

    fwd_sel_t    fwda_c;
    fwd_sel_t    fwdb_c;
    logic        lu;
    logic        mem_req;
    logic        freeze;

    logic        pc_we_c;
    logic        ifid_we_c;
    logic        idex_we_c;
    logic        exmem_we_c;
    logic        ifid_flush_c;
    logic        idex_bubble_c;
    logic        memwb_bubble_c;

    fwd_unit u_fwd_a (
        .src      (bus.id_rs),
        .ex_wreg  (bus.ex_wreg),
        .ex_m2reg (bus.ex_m2reg),
        .ex_wn    (bus.ex_wn),
        .mem_wreg (bus.mem_wreg),
        .mem_wn   (bus.mem_wn),
        .fwd      (fwda_c)
    );

    fwd_unit u_fwd_b (
        .src      (bus.id_rt),
        .ex_wreg  (bus.ex_wreg),
        .ex_m2reg (bus.ex_m2reg),
        .ex_wn    (bus.ex_wn),
        .mem_wreg (bus.mem_wreg),
        .mem_wn   (bus.mem_wn),
        .fwd      (fwdb_c)
    );

    assign lu = bus.ex_wreg && bus.ex_m2reg && bus.ex_wn != REG_ZERO &&
                ((bus.id_use_rs && bus.ex_wn == bus.id_rs) ||
                 (bus.id_use_rt && bus.ex_wn == bus.id_rt));

    assign mem_req = bus.mem_m2reg || bus.mem_wmem;
    assign freeze  = mem_req && !bus.dmem_ack && (state != ERR);

    // NOTE: every output gets a default before the priority chain so no latch is inferred.
    always_comb begin
        pc_we_c        = 1'b1;
        ifid_we_c      = 1'b1;
        idex_we_c      = 1'b1;
        exmem_we_c     = 1'b1;
        ifid_flush_c   = 1'b0;
        idex_bubble_c  = 1'b0;
        memwb_bubble_c = 1'b0;
        if (state == ERR) begin
            pc_we_c        = 1'b0;
            ifid_we_c      = 1'b0;
            idex_we_c      = 1'b0;
            exmem_we_c     = 1'b0;
            idex_bubble_c  = 1'b1;
            memwb_bubble_c = 1'b1;
        end else if (freeze) begin
            pc_we_c        = 1'b0;
            ifid_we_c      = 1'b0;
            idex_we_c      = 1'b0;
            exmem_we_c     = 1'b0;
            memwb_bubble_c = 1'b1;
        end else if (lu) begin
            // Branch is dropped here; it re-resolves once the load data is forwardable.
            pc_we_c       = 1'b0;
            ifid_we_c     = 1'b0;
            idex_bubble_c = 1'b1;
        end else if (bus.id_branch_taken) begin
            ifid_flush_c = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= RUN;
            wcnt      <= 8'd0;
            bus_err_q <= 1'b0;
            stall_q   <= 32'd0;
        end else begin
            if (!pc_we_c && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
            case (state)
                RUN, MEMWAIT: begin
                    if (freeze) begin
                        wcnt <= wcnt + 8'd1;
                        // Checked in RUN too so MEM_TIMEOUT=1 still errors after one cycle.
                        if (wcnt == WCNT_LAST) begin
                            state     <= ERR;
                            bus_err_q <= 1'b1;
                        end else begin
                            state <= MEMWAIT;
                        end
                    end else begin
                        wcnt  <= 8'd0;
                        state <= RUN;
                    end
                end
                ERR:     state <= ERR;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.pc_we        = pc_we_c;
    assign bus.ifid_we      = ifid_we_c;
    assign bus.idex_we      = idex_we_c;
    assign bus.exmem_we     = exmem_we_c;
    assign bus.ifid_flush   = ifid_flush_c;
    assign bus.idex_bubble  = idex_bubble_c;
    assign bus.memwb_bubble = memwb_bubble_c;
    assign bus.fwda         = fwda_c;
    assign bus.fwdb         = fwdb_c;
    assign bus.bus_err      = bus_err_q;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4; expected values are
// hand-computed constants checked with immediate assertions.
module tb_pipe_hazard_ctrl;
    import cpu_pkg::*;

    logic clk;
    logic clrn;
    int   n_vec;
    int   n_err;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        bus.id_rs = 5'd0;  bus.id_rt = 5'd0;
        bus.id_use_rs = 1'b0;  bus.id_use_rt = 1'b0;  bus.id_branch_taken = 1'b0;
        bus.ex_wreg = 1'b0;  bus.ex_m2reg = 1'b0;  bus.ex_wn = 5'd0;
        bus.mem_wreg = 1'b0;  bus.mem_m2reg = 1'b0;  bus.mem_wmem = 1'b0;
        bus.mem_wn = 5'd0;  bus.dmem_ack = 1'b0;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_we(input string tag, input logic [3:0] expected);
        check(tag, {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we}, expected);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        clrn = 1'b0;
        #2;
        check("rst_bus_err", bus.bus_err, 0);
        check("rst_stall", bus.stall_cycles, 0);
        check_we("rst_we", 4'b1111);
        check("rst_ctrl", {bus.ifid_flush, bus.idex_bubble, bus.memwb_bubble}, 3'b000);
        @(negedge clk);
        clrn = 1'b1;
        cyc();

        // Load-use: load to r5 in EX, ID reads r5.
        bus.ex_wreg = 1'b1; bus.ex_m2reg = 1'b1; bus.ex_wn = 5'd5;
        bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
        #1;
        check_we("lu_we", 4'b0011);
        check("lu_bubble", bus.idex_bubble, 1);
        check("lu_fwda_load_ex", bus.fwda, FWD_RF);
        cyc();
        bus.ex_wreg = 1'b0; bus.ex_m2reg = 1'b0; bus.ex_wn = 5'd0;
        bus.mem_wreg = 1'b1; bus.mem_m2reg = 1'b1; bus.mem_wn = 5'd5;
        bus.dmem_ack = 1'b1;
        #1;
        check("lu_next_fwda", bus.fwda, FWD_MEM);
        check("lu_next_stall", bus.stall_cycles, 1);
        check_we("lu_next_we", 4'b1111);
        cyc();

        // Forwarding priority and zero-register exclusion.
        idle();
        bus.ex_wreg = 1'b1; bus.ex_wn = 5'd7;
        bus.mem_wreg = 1'b1; bus.mem_wn = 5'd7; bus.id_rt = 5'd7;
        #1;
        check("fwdb_ex_prio", bus.fwdb, FWD_EX);
        check("fwda_none", bus.fwda, FWD_RF);
        bus.ex_m2reg = 1'b1;
        #1;
        check("fwdb_ex_load_mem", bus.fwdb, FWD_MEM);
        bus.ex_m2reg = 1'b0; bus.ex_wreg = 1'b0;
        bus.id_rs = 5'd7;
        #1;
        check("fwda_mem_only", bus.fwda, FWD_MEM);
        bus.ex_wreg = 1'b1; bus.ex_wn = 5'd0; bus.mem_wn = 5'd0;
        bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        #1;
        check("fwdb_reg_zero", bus.fwdb, FWD_RF);
        check("fwda_reg_zero", bus.fwda, FWD_RF);
        cyc();

        // MEM wait for 3 cycles, then ack.
        idle();
        bus.mem_m2reg = 1'b1;
        #1;
        check_we("wait1_we", 4'b0000);
        check("wait1_mwb", bus.memwb_bubble, 1);
        cyc();
        bus.ex_wreg = 1'b1; bus.ex_m2reg = 1'b1; bus.ex_wn = 5'd9;
        bus.id_rt = 5'd9; bus.id_use_rt = 1'b1;
        #1;
        check("wait2_lu_ignored", {bus.idex_bubble, bus.memwb_bubble}, 2'b01);
        check_we("wait2_we", 4'b0000);
        cyc();
        bus.ex_wreg = 1'b0; bus.ex_m2reg = 1'b0; bus.id_use_rt = 1'b0;
        #1;
        check_we("wait3_we", 4'b0000);
        cyc();
        bus.dmem_ack = 1'b1;
        #1;
        check_we("ack_we", 4'b1111);
        check("ack_mwb", bus.memwb_bubble, 0);
        check("ack_bus_err", bus.bus_err, 0);
        cyc();
        idle();
        #1;
        check("wait_stall", bus.stall_cycles, 4);

        // Branch together with load-use: stall only, flush on the retry.
        bus.ex_wreg = 1'b1; bus.ex_m2reg = 1'b1; bus.ex_wn = 5'd3;
        bus.id_rs = 5'd3; bus.id_use_rs = 1'b1; bus.id_branch_taken = 1'b1;
        #1;
        check("br_lu_flush", bus.ifid_flush, 0);
        check_we("br_lu_we", 4'b0011);
        cyc();
        bus.ex_wreg = 1'b0; bus.ex_m2reg = 1'b0; bus.ex_wn = 5'd0;
        #1;
        check("br_flush", bus.ifid_flush, 1);
        check_we("br_we", 4'b1111);
        check("br_stall", bus.stall_cycles, 5);
        cyc();

        // Reset mid-wait (wcnt=2), then timeout counted afresh.
        idle();
        bus.mem_wmem = 1'b1;
        cyc();
        cyc();
        #1;
        check("mw_bus_err_pre", bus.bus_err, 0);
        clrn = 1'b0;
        #1;
        check("mw_rst_stall", bus.stall_cycles, 0);
        check("mw_rst_bus_err", bus.bus_err, 0);
        check_we("mw_rst_we", 4'b0000);
        clrn = 1'b1;
        cyc();
        cyc();
        cyc();
        #1;
        check("to_before_err", bus.bus_err, 0);
        check_we("to_before_we", 4'b0000);
        cyc();
        #1;
        check("to_bus_err", bus.bus_err, 1);
        check_we("to_err_we", 4'b0000);
        check("to_err_bubbles", {bus.idex_bubble, bus.memwb_bubble}, 2'b11);
        check("to_err_stall", bus.stall_cycles, 4);
        bus.dmem_ack = 1'b1;
        bus.mem_wmem = 1'b0;
        #1;
        check_we("err_sticky_we", 4'b0000);
        cyc();
        #1;
        check("err_sticky", bus.bus_err, 1);
        check("err_stall", bus.stall_cycles, 5);
        clrn = 1'b0;
        #1;
        check("err_rst_bus_err", bus.bus_err, 0);
        check_we("err_rst_we", 4'b1111);
        clrn = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline controller for the 5-stage CPU. It watches register usage in ID and the destinations in EX and MEM, and from that generates forwarding selects, load-use bubbles and branch flushes. It also freezes the pipeline while the data memory holds off a MEM-stage access, and latches a sticky bus error if that access times out. It drives the write-enables and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum consecutive wait cycles allowed for one MEM access before error; legal range 1–255.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt.
- id_branch_taken  in  1  branch/jump resolved taken in ID.
- ex_wreg, ex_m2reg  in  1 each  EX-stage control bits from ID/EX.
- ex_wn  in  5  EX-stage destination register.
- mem_wreg, mem_m2reg, mem_wmem  in  1 each  MEM-stage control bits.
- mem_wn  in  5  MEM-stage destination register.
- dmem_ack  in  1  data memory completes the MEM-stage access this cycle.
- pc_we, ifid_we, idex_we, exmem_we  out  1 each  register write-enables.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_bubble  out  1  zero wreg/m2reg/wmem entering ID/EX.
- memwb_bubble  out  1  zero control entering MEM/WB.
- fwda, fwdb  out  2 each  operand A/B select: 00 register file, 01 EX ALU result, 10 MEM-stage result.
- bus_err  out  1  sticky memory timeout flag.
- stall_cycles  out  32  saturating count of cycles with pc_we=0.

## Operation
- Forwarding (combinational): fwda=01 if ex_wreg & !ex_m2reg & ex_wn!=0 & ex_wn==id_rs; otherwise 10 if mem_wreg & mem_wn!=0 & mem_wn==id_rs; otherwise 00. fwdb uses the same rule with id_rt. An EX match has priority over a MEM match.
- Load-use hazard: lu = ex_wreg & ex_m2reg & ex_wn!=0 & ((id_use_rs & ex_wn==id_rs) | (id_use_rt & ex_wn==id_rt)).
- mem_req = mem_m2reg | mem_wmem. The freeze condition is mem_req & !dmem_ack while in RUN or MEMWAIT.
- FSM states: RUN, MEMWAIT, ERR.
  - RUN→MEMWAIT on freeze.
  - MEMWAIT→RUN on dmem_ack.
  - MEMWAIT→ERR when wcnt==MEM_TIMEOUT-1 and there is still no ack.
  - ERR is left only by reset.
- wcnt is an 8-bit counter. It increments on every frozen cycle and clears to 0 on entry to RUN.
- Output priority, highest first:
  - ERR: all *_we=0, idex_bubble=1, memwb_bubble=1, bus_err=1.
  - Freeze: pc_we=ifid_we=idex_we=exmem_we=0, memwb_bubble=1. lu and branch are ignored.
  - lu: pc_we=ifid_we=0, idex_bubble=1, idex_we=1, exmem_we=1. id_branch_taken is ignored; the branch re-resolves next cycle.
  - id_branch_taken: all we=1, ifid_flush=1.
  - Default: all we=1, all bubble/flush=0.
- stall_cycles increments when pc_we=0 and holds at 32'hFFFF_FFFF.

## Timing
- Forwarding, bubble, flush and we outputs are combinational from the current inputs and state, with zero latency.
- Freeze asserts in the same cycle that mem_req & !dmem_ack is seen. The pipeline advances in the ack cycle.
- ERR is entered after exactly MEM_TIMEOUT frozen cycles without an ack.
- Reset values:
  - State is RUN, wcnt=0, stall_cycles=0, bus_err=0.
  - Outputs follow the RUN rules with the current inputs.
  - Asserting clrn low mid-wait returns to RUN immediately.

## Structure
- Shared package cpu_pkg holds:
  - the forwarding select constants FWD_RF/FWD_EX/FWD_MEM;
  - the FSM state encoding;
  - REG_ZERO=5'd0.
- Sub-module fwd_unit holds the combinational rs/rt compare for one operand and is instantiated twice. The FSM, counters and priority logic stay in the top level.

## Test plan
- EX load with ex_wn=5, ID rs=5 and id_use_rs=1 → for one cycle pc_we=0, ifid_we=0, idex_bubble=1. The next cycle has fwda=10 and stall_cycles=1.
- ex_wn=mem_wn=7, both wreg, ex_m2reg=0, id_rt=7 → fwdb=01. With ex_wn=0 and mem_wn=0 → fwdb=00.
- mem_m2reg=1 with dmem_ack low for 3 cycles then high → 3 frozen cycles with memwb_bubble=1, then RUN and stall_cycles=3.
- MEM_TIMEOUT=4 and dmem_ack never asserted → bus_err=1 from the 5th cycle, and all we stay 0 until clrn.
- id_branch_taken=1 together with a load-use hazard → stall only, no flush. Next cycle with the hazard cleared → ifid_flush=1.
- clrn pulsed low in MEMWAIT with wcnt=2 → state RUN, wcnt=0, bus_err=0, stall_cycles=0.
